// File: rtl/fpga_top_pkg.sv
// rtl/fpga_top_pkg.sv - shared constants for the LUT/register slice
package fpga_top_pkg;
   localparam int unsigned LUT_W = 4;
   localparam int unsigned LUT_DEPTH = 1 << LUT_W;
   localparam logic [LUT_DEPTH-1:0] LUT_INIT_DEFAULT = 16'h6676;
endpackage

// File: rtl/fpga_top_lut4.sv
// rtl/fpga_top_lut4.sv - parameterised 4-input look-up table
import fpga_top_pkg::*;

module lut4 #(
   parameter logic [LUT_DEPTH-1:0] INIT = LUT_INIT_DEFAULT
) (
   input  logic [LUT_W-1:0] in_i,
   output logic             out_o
);
   assign out_o = INIT[in_i];
endmodule

// File: rtl/fpga_top.sv
// rtl/fpga_top.sv - LUT feeding true/complement registers with output select
import fpga_top_pkg::*;

module fpga_top #(
   parameter logic [LUT_DEPTH-1:0] LUT_INIT = LUT_INIT_DEFAULT
) (
   input  logic             clk,
   input  logic             global_resetn,
   input  logic             scan_en,
   input  logic             scan_mode,
   input  logic [LUT_W-1:0] in,
   input  logic             rst,
   input  logic             mux_sel,
   output logic             Q
);
   logic       lut;
   logic [1:0] sync_q;
   logic       rst_sync_n;
   logic       ff_t_q, ff_t_d;
   logic       ff_c_q, ff_c_d;
   logic       unused_scan;

   assign unused_scan = scan_en ^ scan_mode;

   lut4 #(.INIT(LUT_INIT)) u_lut4 (
      .in_i  (in),
      .out_o (lut)
   );

   // Assertion is immediate through the async clear; release waits two clk edges.
   always_ff @(posedge clk or negedge global_resetn) begin
      if (!global_resetn) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], 1'b1};
      end
   end

   assign rst_sync_n = sync_q[1] & global_resetn;

   always_comb begin
      ff_t_d = lut;
      ff_c_d = ~lut;
      if (rst) begin
         ff_t_d = 1'b0;
         ff_c_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         ff_t_q <= 1'b0;
         ff_c_q <= 1'b0;
      end else begin
         ff_t_q <= ff_t_d;
         ff_c_q <= ff_c_d;
      end
   end

   assign Q = mux_sel ? ff_t_q : ff_c_q;
endmodule

// File: tb/tb_fpga_top.sv
// tb/tb_fpga_top.sv - directed self-checking bench for fpga_top
module tb_fpga_top;
   logic       clk;
   logic       global_resetn;
   logic       scan_en;
   logic       scan_mode;
   logic [3:0] in_s;
   logic       rst;
   logic       mux_sel;
   logic       q;

   int n_checks;
   int n_errors;

   fpga_top dut (
      .clk           (clk),
      .global_resetn (global_resetn),
      .scan_en       (scan_en),
      .scan_mode     (scan_mode),
      .in            (in_s),
      .rst           (rst),
      .mux_sel       (mux_sel),
      .Q             (q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic lut_exp(input int v);
      return v inside {1, 2, 4, 5, 6, 9, 10, 13, 14};
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: Q=%b expected %b", tag, obs, exp);
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      global_resetn = 1'b1;
      scan_en = 1'b0;
      scan_mode = 1'b0;
      in_s = 4'd0;
      rst = 1'b1;
      mux_sel = 1'b0;
      #2;
      global_resetn = 1'b0;
      #1;
      chk("greset_sel0", q, 1'b0);
      mux_sel = 1'b1;
      #1;
      chk("greset_sel1", q, 1'b0);
      tick();
      tick();
      chk("greset_clocked", q, 1'b0);

      global_resetn = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         mux_sel = i[0];
         #1;
         chk("rst_hold", q, 1'b0);
      end

      rst = 1'b0;
      in_s = 4'd0;
      tick();
      mux_sel = 1'b1;
      #1;
      chk("in0_true", q, 1'b0);
      mux_sel = 1'b0;
      #1;
      chk("in0_comp", q, 1'b1);
      in_s = 4'b0011;
      tick();
      mux_sel = 1'b1;
      #1;
      chk("in3_true", q, 1'b0);
      mux_sel = 1'b0;
      #1;
      chk("in3_comp", q, 1'b1);

      for (int v = 0; v < 16; v++) begin
         mux_sel = 1'b1;
         in_s = 4'(v);
         #1;
         if (v > 0) chk("sweep_old_value", q, lut_exp(v - 1));
         else chk("sweep_old_value", q, lut_exp(3));
         tick();
         chk("sweep_one_edge", q, lut_exp(v));
         repeat (9) tick();
         chk("sweep_true", q, lut_exp(v));
         mux_sel = 1'b0;
         #1;
         chk("sweep_comp", q, ~lut_exp(v));
      end

      in_s = 4'b0110;
      mux_sel = 1'b1;
      tick();
      chk("pre_rst_q1", q, 1'b1);
      rst = 1'b1;
      tick();
      chk("mid_rst_true", q, 1'b0);
      mux_sel = 1'b0;
      #1;
      chk("mid_rst_comp", q, 1'b0);
      rst = 1'b0;
      in_s = 4'b0010;
      mux_sel = 1'b1;
      #1;
      chk("rst_still_q0", q, 1'b0);
      tick();
      chk("rst_release_q1", q, 1'b1);

      in_s = 4'd0;
      tick();
      chk("simul_pre", q, 1'b0);
      in_s = 4'd1;
      mux_sel = 1'b0;
      #1;
      chk("simul_sel_now", q, 1'b1);
      tick();
      chk("simul_in_next", q, 1'b0);

      mux_sel = 1'b1;
      tick();
      chk("gpulse_pre", q, 1'b1);
      global_resetn = 1'b0;
      #1;
      chk("gpulse_async", q, 1'b0);
      global_resetn = 1'b1;
      #1;
      chk("gpulse_held", q, 1'b0);
      tick();
      tick();
      tick();
      chk("gpulse_recover", q, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/fpga_top.md
FPGA_TOP -- requirements
Module: fpga_top

Interface
REQ-001 Parameter LUT_INIT, default 16'h6676, 4-input truth table; bit index = in[3:0].
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  fabric clock 0; all state updates on the rising edge.
REQ-004 global_resetn  input  1  asynchronous, active-low global reset.
REQ-005 scan_en  input  1  reserved; functional operation requires 0; ignored.
REQ-006 scan_mode  input  1  reserved; functional operation requires 0; ignored.
REQ-007 in  input  4  LUT data inputs.
REQ-008 rst  input  1  user reset; synchronous, active-high.
REQ-009 mux_sel  input  1  output select: 1 = true path, 0 = complement path.
REQ-010 Q  output  1  selected registered result.

Function
REQ-011 lut = LUT_INIT[in], combinational, 4-to-1 index with no other logic.
REQ-012 With the default LUT_INIT, lut = 1 for in ∈ {1,2,4,5,6,9,10,13,14} and 0 for {0,3,7,8,11,12,15}.
REQ-013 Register ff_t captures lut on each rising clk edge.
REQ-014 Register ff_c captures ~lut on each rising clk edge.
REQ-015 Q = mux_sel ? ff_t : ff_c, a purely combinational 2:1 mux.
REQ-016 Q follows mux_sel with zero-cycle latency.
REQ-017 Q follows a change on in with one-cycle latency.
REQ-018 When rst=1 at a rising edge, ff_t and ff_c both load 0, overriding lut.
REQ-019 While rst is held at 1, Q=0 for either mux_sel value and any in.
REQ-020 First rising edge with rst=0 loads lut/~lut normally; there is no extra recovery cycle.
REQ-021 Simultaneous in change and mux_sel change: Q reflects the new mux_sel immediately and the new in one edge later.
REQ-022 Outside reset, exactly one of ff_t and ff_c is 1.

Reset
REQ-023 global_resetn=0 clears ff_t and ff_c to 0 immediately, independent of clk.
REQ-024 Q therefore reads 0 during global reset.
REQ-025 global_resetn has priority over rst and over the data path.
REQ-026 Deassertion of global_resetn is synchronised to clk: a 2-flop release synchroniser clears asynchronously and releases synchronously.
REQ-027 Mid-operation assertion of either reset forces Q=0 per REQ-019/REQ-024, without X propagation.
REQ-028 Every output is defined after reset; Q reset value = 0.

Structure
REQ-029 Shared package fpga_top_pkg holds the LUT_INIT default constant (16'h6676) and the LUT input width (4).
REQ-030 One sub-module, lut4: a parameterised 4-input LUT with an INIT parameter and a combinational output.
REQ-031 Registers, reset synchroniser and output mux reside in fpga_top.

Verification
REQ-032 global_resetn=0 with rst=1, in=0 → Q=0. Then release global_resetn, rst 1 for 10 cycles → Q=0 for mux_sel 0 and 1.
REQ-033 rst=0, in=0: mux_sel=1 → Q=0; mux_sel=0 → Q=1. Also in=4'b0011: mux_sel=1 → Q=0; mux_sel=0 → Q=1.
REQ-034 Sweep in=0..15 with 10 cycles each, checking both mux_sel values; e.g. in=4'b0101 → 1/0; in=4'b1000 → 0/1; in=4'b1100 → 0/1; in=4'b1111 → 0/1.
REQ-035 Assert rst=1 mid-sweep with in=4'b0110 → Q=0 for both mux_sel values within 1 cycle. Deassert with in=4'b0010, mux_sel=1 → Q=1 after 1 edge.
REQ-036 Pulse global_resetn low between clk edges while Q=1 → Q falls to 0 without a clock edge.
